flex_counter_bank: RTL and testbench



---
 rtl/flex_counter_bank.sv | 70 +++++++
 tb/tb_flex_counter_bank.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/flex_counter_bank.sv
// flex_counter_bank: NUM_CH independent up/down counters with clamped load, compare match and sticky irq.
// Define COUNTER_BANK_PRESCALE_EN to gate counting with a shared divide-by-PRESCALE tick.
module flex_counter_bank #(
    parameter int NUM_CH   = 4,
    parameter int WIDTH    = 24,
    parameter int PRESCALE = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_CH-1:0]             enable,
    input  logic [NUM_CH-1:0]             clear,
    input  logic [NUM_CH-1:0]             up_down,
    input  logic [NUM_CH-1:0]             load,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  load_val,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  rollover_val,
    input  logic [NUM_CH-1:0][WIDTH-1:0]  flag_compare,
    input  logic [NUM_CH-1:0]             irq_clear,
    output logic [NUM_CH-1:0][WIDTH-1:0]  count,
    output logic [NUM_CH-1:0]             match_flag,
    output logic [NUM_CH-1:0]             rollover_flag,
    output logic [NUM_CH-1:0]             irq
);
    if (NUM_CH < 1 || NUM_CH > 8 || WIDTH < 2 || WIDTH > 32 || PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_cfg
        $error("flex_counter_bank: parameter out of range");
    end
    logic tick;
`ifdef COUNTER_BANK_PRESCALE_EN
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] div;
    always_ff @(posedge CLK or posedge RST)
        if (RST) div <= '0;
        else div <= (div == LAST) ? '0 : div + 1'b1;
    assign tick = div == LAST;
`else
    assign tick = 1'b1;
`endif
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] cnt, rv, nxt;
        logic step, wrap, match, match_d, roll, irq_r;
        assign rv   = rollover_val[c];
        assign step = enable[c] && tick && !clear[c] && !load[c];
        // >= on the up path also wraps a count stranded above a lowered rollover_val
        assign wrap = step && (up_down[c] ? cnt >= rv : cnt == '0);
        always_comb
            nxt = clear[c] ? '0 :
                  load[c]  ? ((load_val[c] > rv) ? rv : load_val[c]) :
                  !step    ? cnt :
                  wrap     ? (up_down[c] ? '0 : rv) :
                  up_down[c] ? cnt + 1'b1 : cnt - 1'b1;
        always_ff @(posedge CLK or posedge RST)
            if (RST) begin
                cnt     <= '0;
                match   <= 1'b0;
                match_d <= 1'b0;
                roll    <= 1'b0;
                irq_r   <= 1'b0;
            end else begin
                cnt     <= nxt;
                match   <= nxt == flag_compare[c];
                match_d <= match;
                roll    <= wrap;
                irq_r   <= (match & ~match_d) | (irq_r & ~irq_clear[c]);
            end
        assign count[c]         = cnt;
        assign match_flag[c]    = match;
        assign rollover_flag[c] = roll;
        assign irq[c]           = irq_r;
    end
endmodule

// File: tb/tb_flex_counter_bank.sv
// tb_flex_counter_bank: scoreboard bench; a behavioural model queues expected outputs per cycle.
module tb_flex_counter_bank;
    localparam int N = 4, W = 8, P = 4;
    logic CLK = 1'b0, RST = 1'b1;
    logic [N-1:0] enable = '0, clear = '0, up_down = '1, load = '0, irq_clear = '0;
    logic [N-1:0][W-1:0] load_val = '0, rollover_val = '0, flag_compare = '1;
    logic [N-1:0][W-1:0] count;
    logic [N-1:0] match_flag, rollover_flag, irq;

    flex_counter_bank #(.NUM_CH(N), .WIDTH(W), .PRESCALE(P)) dut (
        .CLK(CLK), .RST(RST), .enable(enable), .clear(clear), .up_down(up_down),
        .load(load), .load_val(load_val), .rollover_val(rollover_val),
        .flag_compare(flag_compare), .irq_clear(irq_clear), .count(count),
        .match_flag(match_flag), .rollover_flag(rollover_flag), .irq(irq)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [N-1:0][W-1:0] c;
        logic [N-1:0] m, r, i;
    } exp_t;
    exp_t sb[$];
    int vectors = 0, miscompares = 0;
    logic [N-1:0][W-1:0] mc;
    logic [N-1:0] mm, mmp, mr, mi;
    int pcnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        mc = '0; mm = '0; mmp = '0; mr = '0; mi = '0; pcnt = 0;
    endtask

    // advance the model by one clock using the inputs now being driven
    task automatic predict();
        logic tick;
        logic [W-1:0] n;
        logic [N-1:0] ni;
`ifdef COUNTER_BANK_PRESCALE_EN
        tick = (pcnt == P - 1);
        pcnt = tick ? 0 : pcnt + 1;
`else
        tick = 1'b1;
`endif
        ni = (mm & ~mmp) | (mi & ~irq_clear);
        mmp = mm;
        for (int k = 0; k < N; k++) begin
            mr[k] = 1'b0;
            if (clear[k]) n = '0;
            else if (load[k]) n = (load_val[k] > rollover_val[k]) ? rollover_val[k] : load_val[k];
            else if (enable[k] && tick) begin
                if (up_down[k]) begin
                    if (mc[k] >= rollover_val[k]) begin n = '0; mr[k] = 1'b1; end
                    else n = mc[k] + 8'd1;
                end else begin
                    if (mc[k] == '0) begin n = rollover_val[k]; mr[k] = 1'b1; end
                    else n = mc[k] - 8'd1;
                end
            end else n = mc[k];
            mc[k] = n;
            mm[k] = (n == flag_compare[k]);
        end
        mi = ni;
        sb.push_back('{c: mc, m: mm, r: mr, i: mi});
    endtask

    task automatic cyc();
        exp_t e;
        predict();
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        check("count", count, e.c);
        check("match_flag", match_flag, e.m);
        check("rollover_flag", rollover_flag, e.r);
        check("irq", irq, e.i);
    endtask

    int seq_c[6] = '{9, 8, 7, 8, 9, 0};
    int seq_r[6] = '{1, 0, 0, 0, 0, 1};

    initial begin
        model_reset();
        #12 RST = 1'b0;
        check("reset_count", count, '0);
        check("reset_irq", irq, '0);
        // count ch0 to 5, then reset asynchronously mid-cycle
        rollover_val[0] = 8'd10; enable[0] = 1'b1;
        for (int k = 0; k < 5; k++) cyc();
`ifndef COUNTER_BANK_PRESCALE_EN
        check("pre_rst_count5", count[0], 8'd5);
`endif
        #2 RST = 1'b1;
        #1;
        check("async_rst_count", count, '0);
        check("async_rst_match", match_flag, '0);
        check("async_rst_roll", rollover_flag, '0);
        check("async_rst_irq", irq, '0);
        @(posedge CLK);
        #1 RST = 1'b0;
        model_reset();
        // ch0 up wrap at 3
        rollover_val[0] = 8'd3;
        for (int k = 0; k < 4; k++) begin
            cyc();
`ifndef COUNTER_BANK_PRESCALE_EN
            check("ch0_up_seq", count[0], (k + 1) % 4);
            check("ch0_up_roll", rollover_flag[0], k == 3);
`endif
        end
        enable[0] = 1'b0;
        // ch1 down from 0 with wrap, then flip direction
        rollover_val[1] = 8'd9; up_down[1] = 1'b0; enable[1] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 3) up_down[1] = 1'b1;
            cyc();
`ifndef COUNTER_BANK_PRESCALE_EN
            check("ch1_dir_seq", count[1], seq_c[k]);
            check("ch1_dir_roll", rollover_flag[1], seq_r[k][0]);
`endif
        end
        enable[1] = 1'b0;
        // ch2 priority: clear beats load and enable, then clamped load
        rollover_val[2] = 8'd15; clear[2] = 1'b1; load[2] = 1'b1; load_val[2] = 8'd7; enable[2] = 1'b1;
        cyc();
        check("ch2_clear_wins", count[2], 8'd0);
        clear[2] = 1'b0; load_val[2] = 8'd20;
        cyc();
        check("ch2_load_clamp", count[2], 8'd15);
        load[2] = 1'b0; enable[2] = 1'b0;
        // ch3 match and sticky irq
        rollover_val[3] = 8'd255; flag_compare[3] = 8'd4; enable[3] = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        irq_clear[3] = 1'b1;
        cyc();
        irq_clear[3] = 1'b0;
        check("ch3_irq_cleared", irq[3], 1'b0);
        load[3] = 1'b1; load_val[3] = 8'd3;
        cyc();
        load[3] = 1'b0;
        for (int k = 0; k < P + 1 && !match_flag[3]; k++) cyc();
        check("ch3_match_rise", match_flag[3], 1'b1);
        irq_clear[3] = 1'b1;
        cyc();
        irq_clear[3] = 1'b0;
        check("ch3_set_beats_clear", irq[3], 1'b1);
        cyc();
        enable = '0;
        // independence run
        clear = '1;
        cyc();
        clear = '0;
        rollover_val[0] = 8'd2; rollover_val[1] = 8'd5; rollover_val[2] = 8'd0; rollover_val[3] = 8'd255;
        flag_compare[0] = 8'd1; flag_compare[1] = 8'd3; flag_compare[2] = 8'd0; flag_compare[3] = 8'd100;
        enable = '1; up_down = '1;
        for (int k = 0; k < 300; k++) begin
            cyc();
`ifndef COUNTER_BANK_PRESCALE_EN
            if (k % 50 == 0) begin
                check("ch2_rv0_hold", count[2], 8'd0);
                check("ch2_rv0_roll", rollover_flag[2], 1'b1);
            end
`endif
        end
        // randomised traffic, including rollover_val changes while counting
        for (int k = 0; k < 300; k++) begin
            for (int j = 0; j < N; j++) begin
                enable[j]    = $urandom_range(0, 3) != 0;
                clear[j]     = $urandom_range(0, 19) == 0;
                load[j]      = $urandom_range(0, 9) == 0;
                up_down[j]   = $urandom_range(0, 5) != 0 ? up_down[j] : ~up_down[j];
                irq_clear[j] = $urandom_range(0, 7) == 0;
                load_val[j]  = W'($urandom);
                if ($urandom_range(0, 15) == 0) rollover_val[j] = W'($urandom_range(0, 20));
                if ($urandom_range(0, 15) == 0) flag_compare[j] = W'($urandom_range(0, 20));
            end
            cyc();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
